// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN     = 16;
    localparam int unsigned OPC_BITS = 4;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] instr_t;

    localparam logic [OPC_BITS-1:0] OPC_JMP = 4'b1101;
    localparam logic [OPC_BITS-1:0] OPC_BEQ = 4'b1011;
    localparam logic [OPC_BITS-1:0] OPC_BNE = 4'b1100;
    localparam pc_t                 PC_STEP = 16'd2;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
        logic   pred_taken;
    } ifid_payload_t;

    // JMP target: page bits come from the sequential PC, the rest from the 12-bit immediate.
    function automatic pc_t jmp_target(input pc_t pc_plus2, input instr_t instr);
        return {pc_plus2[15:13], instr[11:0], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with stall (hold) and flush (bubble) control.
module if_id_reg
    import if_fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          load_i,
    input  ifid_payload_t payload_i,
    output logic          valid_o,
    output instr_t        instr_o,
    output pc_t           pc_o,
    output pc_t           pc_plus2_o,
    output logic          pred_taken_o
);

    logic   valid_q, valid_d;
    instr_t instr_q, instr_d;
    pc_t    pc_q, pc_d;
    pc_t    pc_plus2_q, pc_plus2_d;
    logic   pred_q, pred_d;

    // Flush beats stall; payload fields keep their last value whenever valid drops.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus2_d = pc_plus2_q;
        pred_d     = pred_q;
        if (flush_i) begin
            valid_d = 1'b0;
            pred_d  = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = payload_i.instr;
            pc_d       = payload_i.pc;
            pc_plus2_d = payload_i.pc + PC_STEP;
            pred_d     = payload_i.pred_taken;
        end else begin
            valid_d = 1'b0;
            pred_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus2_q <= PC_STEP;
            pred_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus2_q <= pc_plus2_d;
            pred_q     <= pred_d;
        end
    end

    assign valid_o      = valid_q;
    assign instr_o      = instr_q;
    assign pc_o         = pc_q;
    assign pc_plus2_o   = pc_plus2_q;
    assign pred_taken_o = pred_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALT control, next-PC mux and IF/ID capture.
// Optional FETCH_EARLY_JUMP_EN follows JMP at fetch time instead of waiting for execute.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter pc_t RESET_PC = 16'h0000,
    parameter pc_t PC_LIMIT = 16'h001E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic [15:0] imem_pc_o,
    input  logic [15:0] imem_instr_i,
    output logic        ifid_valid_o,
    output logic [15:0] ifid_instr_o,
    output logic [15:0] ifid_pc_o,
    output logic [15:0] ifid_pc_plus2_o,
    output logic        ifid_pred_taken_o,
    output logic        halted_o
);

    fetch_state_e  state_q, state_d;
    pc_t           pc_q, pc_d;
    pc_t           pc_plus2_c;
    logic          fetch_c;
    logic          pred_c;
    ifid_payload_t payload_c;
    logic          unused_redirect_lsb;

    // Instructions are halfword aligned, so the redirect LSB is discarded.
    assign unused_redirect_lsb = redirect_pc_i[0];
    assign pc_plus2_c          = pc_q + PC_STEP;

    // Next-state / next-PC: redirect > stall > normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch_c = 1'b0;
        pred_c  = 1'b0;
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[15:1], 1'b0};
            state_d = FS_RUN;
        end else if (!stall_i) begin
            case (state_q)
                FS_RUN: begin
                    if (pc_q < PC_LIMIT) begin
                        fetch_c = 1'b1;
                        pc_d    = pc_plus2_c;
`ifdef FETCH_EARLY_JUMP_EN
                        if (imem_instr_i[15:12] == OPC_JMP) begin
                            pc_d   = jmp_target(pc_plus2_c, imem_instr_i);
                            pred_c = 1'b1;
                        end
`endif
                    end else begin
                        state_d = FS_HALT;
                    end
                end
                FS_HALT: state_d = FS_HALT;
                default: state_d = FS_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        payload_c            = '0;
        payload_c.instr      = imem_instr_i;
        payload_c.pc         = pc_q;
        payload_c.pred_taken = pred_c;
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_i),
        .stall_i      (stall_i),
        .load_i       (fetch_c),
        .payload_i    (payload_c),
        .valid_o      (ifid_valid_o),
        .instr_o      (ifid_instr_o),
        .pc_o         (ifid_pc_o),
        .pc_plus2_o   (ifid_pc_plus2_o),
        .pred_taken_o (ifid_pred_taken_o)
    );

    assign imem_pc_o = pc_q;
    assign halted_o  = (state_q == FS_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: cycle model plus directed literal checks.
module tb_if_fetch_stage;

    localparam logic [15:0] LIMIT = 16'h001E;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] imem_pc_o;
    logic [15:0] imem_instr_i;
    logic        ifid_valid_o;
    logic [15:0] ifid_instr_o;
    logic [15:0] ifid_pc_o;
    logic [15:0] ifid_pc_plus2_o;
    logic        ifid_pred_taken_o;
    logic        halted_o;

    logic [15:0] rom [16];

    int pass_cnt  = 0;
    int check_cnt = 0;

    if_fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_pc_o         (imem_pc_o),
        .imem_instr_i      (imem_instr_i),
        .ifid_valid_o      (ifid_valid_o),
        .ifid_instr_o      (ifid_instr_o),
        .ifid_pc_o         (ifid_pc_o),
        .ifid_pc_plus2_o   (ifid_pc_plus2_o),
        .ifid_pred_taken_o (ifid_pred_taken_o),
        .halted_o          (halted_o)
    );

    always #5 clk = ~clk;

    assign imem_instr_i = rom[imem_pc_o[4:1]];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one fetch per unstalled edge, in program order.
    logic [15:0] m_pc, m_instr, m_ifpc, m_pc2;
    logic        m_valid, m_pred, m_halt;

    always @(posedge clk or posedge rst) begin
        logic [15:0] word, nxt;
        if (rst) begin
            m_pc <= 16'h0000; m_halt <= 1'b0; m_valid <= 1'b0; m_instr <= 16'h0;
            m_ifpc <= 16'h0; m_pc2 <= 16'h0002; m_pred <= 1'b0;
        end else if (redirect_i) begin
            m_pc <= redirect_pc_i & 16'hFFFE; m_halt <= 1'b0; m_valid <= 1'b0; m_pred <= 1'b0;
        end else if (stall_i) begin
            m_pc <= m_pc;
        end else if (!m_halt && m_pc < LIMIT) begin
            word = rom[m_pc[4:1]];
            nxt  = m_pc + 16'd2;
            m_pred <= 1'b0;
`ifdef FETCH_EARLY_JUMP_EN
            if (word[15:12] == 4'hD) begin
                nxt = (nxt & 16'hE000) | ((word & 16'h0FFF) << 1);
                m_pred <= 1'b1;
            end
`endif
            m_valid <= 1'b1; m_instr <= word; m_ifpc <= m_pc; m_pc2 <= m_pc + 16'd2;
            m_pc <= nxt;
        end else begin
            m_halt <= 1'b1; m_valid <= 1'b0; m_pred <= 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("imem_pc", imem_pc_o, m_pc);
        check("halted", 16'(halted_o), 16'(m_halt));
        check("valid", 16'(ifid_valid_o), 16'(m_valid));
        check("pred", 16'(ifid_pred_taken_o), 16'(m_pred));
        check("ifid_instr", ifid_instr_o, m_instr);
        check("ifid_pc", ifid_pc_o, m_ifpc);
        check("ifid_pc2", ifid_pc_plus2_o, m_pc2);
    end

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
        stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    endtask

    initial begin
        logic [15:0] last_pc;
        bit          done;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i) * 16'h0111;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_pc", imem_pc_o, 16'h0000);
        check("rst_valid", 16'(ifid_valid_o), 16'h0);
        check("rst_pc2", ifid_pc_plus2_o, 16'h0002);
        check("rst_instr", ifid_instr_o, 16'h0000);
        check("rst_halted", 16'(halted_o), 16'h0);
        #1 rst = 1'b0;

        @(negedge clk);
        check("e1_imem_pc", imem_pc_o, 16'h0002);
        check("e1_ifid_pc", ifid_pc_o, 16'h0000);
        check("e1_valid", 16'(ifid_valid_o), 16'h1);
        check("e1_instr", ifid_instr_o, 16'h1000);
        @(negedge clk);
        check("e2_ifid_pc", ifid_pc_o, 16'h0002);
        @(negedge clk);
        check("pre_stall_pc", imem_pc_o, 16'h0006);

        drive(1'b1, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check("stall_pc", imem_pc_o, 16'h0006);
        check("stall_instr", ifid_instr_o, 16'h1222);
        drive(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("resume_pc6", ifid_pc_o, 16'h0006);
        @(negedge clk);
        check("resume_pc8", ifid_pc_o, 16'h0008);

        drive(1'b1, 1'b1, 16'h0003);
        @(negedge clk);
        check("redir_pc", imem_pc_o, 16'h0002);
        check("redir_bubble", 16'(ifid_valid_o), 16'h0);
        drive(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("redir_ifid_pc", ifid_pc_o, 16'h0002);
        check("redir_valid", 16'(ifid_valid_o), 16'h1);

        last_pc = 16'hFFFF;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (ifid_valid_o) last_pc = ifid_pc_o;
            if (halted_o) done = 1'b1;
            else @(negedge clk);
        end
        check("halt_reached", 16'(done), 16'h1);
        check("last_valid_pc", last_pc, 16'h001C);
        check("halt_valid", 16'(ifid_valid_o), 16'h0);
        check("halt_pc", imem_pc_o, 16'h001E);
        @(negedge clk);
        check("halt_hold", 16'(halted_o), 16'h1);

        drive(1'b0, 1'b1, 16'h0000);
        @(negedge clk);
        check("restart_halted", 16'(halted_o), 16'h0);
        check("restart_pc", imem_pc_o, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("restart_fetch", ifid_pc_o, 16'h0000);

        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (imem_pc_o == 16'h0010) done = 1'b1;
            else @(negedge clk);
        end
        check("reach_0x10", 16'(done), 16'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_pc", imem_pc_o, 16'h0000);
        check("arst_valid", 16'(ifid_valid_o), 16'h0);
        check("arst_instr", ifid_instr_o, 16'h0000);
        check("arst_ifid_pc", ifid_pc_o, 16'h0000);
        check("arst_pc2", ifid_pc_plus2_o, 16'h0002);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_arst_pc", imem_pc_o, 16'h0002);

        rom[2] = 16'hD005;
        @(negedge clk);
        check("jmp_pre", imem_pc_o, 16'h0004);
        @(negedge clk);
        check("jmp_ifid_pc", ifid_pc_o, 16'h0004);
        check("jmp_instr", ifid_instr_o, 16'hD005);
        check("jmp_valid", 16'(ifid_valid_o), 16'h1);
`ifdef FETCH_EARLY_JUMP_EN
        check("jmp_next_pc", imem_pc_o, 16'h000A);
        check("jmp_pred", 16'(ifid_pred_taken_o), 16'h1);
`else
        check("jmp_next_pc", imem_pc_o, 16'h0006);
        check("jmp_pred", 16'(ifid_pred_taken_o), 16'h0);
`endif
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
